// File: rtl/usart_proto_pkg.sv
// rtl/usart_proto_pkg.sv - shared frame constants, state encoding and checksum for the usart command protocol
package usart_proto_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_PING  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_START = 8'h04;

    localparam logic [7:0] RSP_PING  = 8'h81;
    localparam logic [7:0] RSP_WRITE = 8'h82;
    localparam logic [7:0] RSP_READ  = 8'h83;
    localparam logic [7:0] RSP_START = 8'h84;
    localparam logic [7:0] RSP_ERROR = 8'hFF;

    localparam logic [7:0] ERR_CHECKSUM = 8'h01;
    localparam logic [7:0] ERR_UNKNOWN  = 8'h02;
    localparam logic [7:0] ERR_RX       = 8'h03;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_CMD,
        ST_ARG0,
        ST_ARG1,
        ST_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_TX_SYNC,
        ST_TX_CODE,
        ST_TX_PAY,
        ST_TX_CHK
    } state_t;

    // Command frames XOR three bytes; responses pass 8'h00 as the third operand.
    function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/usart_frame_timeout.sv
// rtl/usart_frame_timeout.sv - inter-byte silence counter that flags a stale partial frame
module usart_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    // A received byte restarts the window; the counter only runs while a frame is open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_expire = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/usart_cmd_responder.sv
// rtl/usart_cmd_responder.sv - parses 5-byte command frames and returns 4-byte response frames
module usart_cmd_responder
    import usart_proto_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_fetch,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       cap_start,
    output logic       busy
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cmd;
    logic [7:0] r_arg0;
    logic [7:0] r_arg1;
    logic [7:0] r_code;
    logic [7:0] r_pay;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_chk_ok;
    logic       w_in_frame;
    logic       w_expire;
    logic       w_chk_match;

    assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_ARG0) ||
                         (r_state == ST_ARG1) || (r_state == ST_CHK);
    assign w_chk_match = (rx_data == frame_chk(r_cmd, r_arg0, r_arg1));
    assign reg_addr    = r_reg_addr;
    assign reg_wdata   = r_reg_wdata;

    usart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .i_clear (rx_ready),
        .i_enable(w_in_frame),
        .o_expire(w_expire)
    );

    // State register; an async reset abandons any response in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: rx_error outranks a byte, a byte outranks the silence timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT:    if (rx_ready && (rx_data == SYNC_BYTE)) w_state_next = ST_CMD;
            ST_CMD, ST_ARG0, ST_ARG1, ST_CHK: begin
                if (rx_error) begin
                    w_state_next = ST_TX_SYNC;
                end else if (rx_ready) begin
                    case (r_state)
                        ST_CMD:  w_state_next = ST_ARG0;
                        ST_ARG0: w_state_next = ST_ARG1;
                        ST_ARG1: w_state_next = ST_CHK;
                        default: w_state_next = ST_EXEC;
                    endcase
                end else if (w_expire) begin
                    w_state_next = ST_HUNT;
                end
            end
            ST_EXEC:    w_state_next = (r_chk_ok && (r_cmd == CMD_READ)) ? ST_RD_WAIT : ST_TX_SYNC;
            ST_RD_WAIT: w_state_next = ST_TX_SYNC;
            ST_TX_SYNC: if (tx_fetch) w_state_next = ST_TX_CODE;
            ST_TX_CODE: if (tx_fetch) w_state_next = ST_TX_PAY;
            ST_TX_PAY:  if (tx_fetch) w_state_next = ST_TX_CHK;
            ST_TX_CHK:  if (tx_fetch) w_state_next = ST_HUNT;
            default:    w_state_next = ST_HUNT;
        endcase
    end

    // Frame capture and response build; the register bus is loaded with the CHK byte
    // so reg_addr is already settled during EXEC and reg_rdata is ready in RD_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd       <= '0;
            r_arg0      <= '0;
            r_arg1      <= '0;
            r_code      <= '0;
            r_pay       <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_chk_ok    <= 1'b0;
        end else begin
            case (r_state)
                ST_CMD, ST_ARG0, ST_ARG1, ST_CHK: begin
                    if (rx_error) begin
                        r_code <= RSP_ERROR;
                        r_pay  <= ERR_RX;
                    end else if (rx_ready) begin
                        case (r_state)
                            ST_CMD:  r_cmd  <= rx_data;
                            ST_ARG0: r_arg0 <= rx_data;
                            ST_ARG1: r_arg1 <= rx_data;
                            default: begin
                                r_chk_ok <= w_chk_match;
                                if (w_chk_match && ((r_cmd == CMD_WRITE) || (r_cmd == CMD_READ)))
                                    r_reg_addr <= r_arg0;
                                if (w_chk_match && (r_cmd == CMD_WRITE))
                                    r_reg_wdata <= r_arg1;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (!r_chk_ok) begin
                        r_code <= RSP_ERROR;
                        r_pay  <= ERR_CHECKSUM;
                    end else begin
                        case (r_cmd)
                            CMD_PING:  begin r_code <= RSP_PING;  r_pay <= 8'h00;       end
                            CMD_WRITE: begin r_code <= RSP_WRITE; r_pay <= r_arg0;      end
                            CMD_READ:  begin r_code <= RSP_READ;  r_pay <= 8'h00;       end
                            CMD_START: begin r_code <= RSP_START; r_pay <= 8'h00;       end
                            default:   begin r_code <= RSP_ERROR; r_pay <= ERR_UNKNOWN; end
                        endcase
                    end
                end
                ST_RD_WAIT: r_pay <= reg_rdata;
                default: ;
            endcase
        end
    end

    // Moore outputs: strobes live only in EXEC, tx_write spans all four response bytes.
    always_comb begin
        tx_data   = 8'h00;
        tx_write  = 1'b0;
        reg_we    = 1'b0;
        cap_start = 1'b0;
        busy      = (r_state != ST_HUNT);
        case (r_state)
            ST_EXEC: begin
                reg_we    = r_chk_ok && (r_cmd == CMD_WRITE);
                cap_start = r_chk_ok && (r_cmd == CMD_START);
            end
            ST_TX_SYNC: begin tx_write = 1'b1; tx_data = SYNC_BYTE; end
            ST_TX_CODE: begin tx_write = 1'b1; tx_data = r_code;    end
            ST_TX_PAY:  begin tx_write = 1'b1; tx_data = r_pay;     end
            ST_TX_CHK:  begin tx_write = 1'b1; tx_data = frame_chk(r_code, r_pay, 8'h00); end
            default: ;
        endcase
    end

endmodule
